// File: rtl/deaggregator.sv
// Deaggregator: splits wide words from an upstream show-ahead FIFO into a
// stream of DATA_WIDTH words for a downstream FIFO, word 0 first.
// A two-entry ping-pong buffer lets the next wide word be captured while the
// current one drains, so a continuously fed stream has no output bubbles.
//
// Ports:
//   clk             - clock, rising edge
//   rst_n           - asynchronous active-low reset
//   sender_data     - packed wide word (word i at bits [(i+1)*DW-1 : i*DW])
//   sender_empty_n  - upstream has a valid word
//   sender_deq      - dequeue strobe; sender_data captured on the same edge
//   receiver_data   - current serial word
//   receiver_full_n - downstream can accept a word
//   receiver_enq    - enqueue strobe; receiver_data transferred on the same edge
module deaggregator #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FETCH_WIDTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
  input  logic                              sender_empty_n,
  output logic                              sender_deq,
  output logic [DATA_WIDTH-1:0]             receiver_data,
  input  logic                              receiver_full_n,
  output logic                              receiver_enq
);

  localparam int unsigned WideW = FETCH_WIDTH * DATA_WIDTH;
  localparam int unsigned IdxW  = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(FETCH_WIDTH - 1);

  logic [WideW-1:0] buf_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             last_word;
  logic             retire;

  // A full buffer blocks dequeue even when the head retires this cycle.
  assign sender_deq   = rst_n & sender_empty_n & (count_q != 2'd2);
  assign receiver_enq = rst_n & (count_q != 2'd0) & receiver_full_n;

  always_comb begin
    receiver_data = '0;
    for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
      if (idx_q == IdxW'(i)) begin
        receiver_data = buf_q[rd_ptr_q][i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    last_word = (idx_q == LastIdx);
    retire    = receiver_enq & last_word;
    idx_d     = idx_q;
    if (receiver_enq) begin
      idx_d = last_word ? '0 : idx_q + 1'b1;
    end
    rd_ptr_d = rd_ptr_q ^ retire;
    wr_ptr_d = wr_ptr_q ^ sender_deq;
    count_d  = count_q;
    unique case ({sender_deq, retire})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      idx_q    <= '0;
    end else begin
      if (sender_deq) begin
        buf_q[wr_ptr_q] <= sender_data;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
    end
  end

endmodule
